// File: rtl/axi_bram_slave.sv
// AXI4 responder backed by a single-port-per-direction BRAM: 128-bit beats, INCR/FIXED bursts.
// Independent write (AW/W/B) and read (AR/R) engines; one burst outstanding per direction.
module axi_bram_slave #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic [7:0]            S_AXI_AWLEN,
  input  logic [1:0]            S_AXI_AWBURST,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_W-1:0]     S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [1:0]            S_AXI_ARBURST,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_W-1:0]     S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RSend} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_e              w_state_q;
  logic [DEPTH_LOG2-1:0] w_idx_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic                  w_fixed_q;
  logic                  w_err_q;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_err_d;

  r_state_e              r_state_q;
  logic [DEPTH_LOG2-1:0] r_idx_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic                  r_fixed_q;

  // Byte offset and aliasing upper address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_RRESP = 2'b00;

  assign w_beat      = (w_state_q == WData) && S_AXI_WVALID && S_AXI_WREADY && !rst;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_err_d     = w_err_q | (S_AXI_WLAST != w_last_beat);

  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q     <= WIdle;
      w_idx_q       <= '0;
      w_len_q       <= '0;
      w_cnt_q       <= '0;
      w_fixed_q     <= 1'b0;
      w_err_q       <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
    end else begin
      case (w_state_q)
        WIdle: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_idx_q       <= S_AXI_AWADDR[DEPTH_LOG2+3:4];
            w_len_q       <= S_AXI_AWLEN;
            w_fixed_q     <= (S_AXI_AWBURST == 2'b00);
            w_cnt_q       <= '0;
            w_err_q       <= 1'b0;
            w_state_q     <= WData;
          end
        end
        WData: begin
          if (S_AXI_WVALID) begin
            // The beat count, not WLAST, ends the burst; a WLAST mismatch only flags SLVERR.
            if (w_last_beat) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= w_err_d ? 2'b10 : 2'b00;
              w_state_q    <= WResp;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
              w_err_q <= w_err_d;
              if (!w_fixed_q) w_idx_q <= w_idx_q + DEPTH_LOG2'(1);
            end
          end
        end
        WResp: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            w_state_q     <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q     <= RIdle;
      r_idx_q       <= '0;
      r_len_q       <= '0;
      r_cnt_q       <= '0;
      r_fixed_q     <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            r_idx_q       <= S_AXI_ARADDR[DEPTH_LOG2+3:4];
            r_len_q       <= S_AXI_ARLEN;
            r_fixed_q     <= (S_AXI_ARBURST == 2'b00);
            r_cnt_q       <= '0;
            r_state_q     <= RFetch;
          end
        end
        RFetch: begin
          // Synchronous read of the old contents if the writer hits the same line this edge.
          S_AXI_RDATA  <= mem[r_idx_q];
          S_AXI_RLAST  <= (r_cnt_q == r_len_q);
          S_AXI_RVALID <= 1'b1;
          r_state_q    <= RSend;
        end
        RSend: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RLAST  <= 1'b0;
            if (S_AXI_RLAST) begin
              S_AXI_ARREADY <= 1'b1;
              r_state_q     <= RIdle;
            end else begin
              r_cnt_q   <= r_cnt_q + 8'd1;
              r_state_q <= RFetch;
              if (!r_fixed_q) r_idx_q <= r_idx_q + DEPTH_LOG2'(1);
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

endmodule
